// File: rtl/vector_mem_responder.sv
// vector_mem_responder
// Memory-side responder for the vector CPU data port. One vector load/store
// request (R lanes of N bits at a byte address) is accepted at a time. It is
// serialised into R single-lane accesses on an internal word-per-lane RAM, and
// the loaded vector or a store acknowledge is returned on a valid/ready
// response channel.
//
// Ports:
//   clk, reset              single clock; asynchronous active-high reset
//   req_valid / req_ready   request handshake
//   req_we                  1 = store, 0 = load
//   req_addr [I-1:0]        byte address of lane 0 (lane k at req_addr+k)
//   req_wdata [R-1:0][N-1:0] store data per lane
//   resp_valid / resp_ready response handshake
//   resp_we                 echo of the answered request's req_we
//   resp_rdata [R-1:0][N-1:0] load data (zero for stores and rejected requests)
//   resp_err                request rejected by the bounds check
//
// Configuration macro:
//   VMEM_BOUNDS_CHECK_EN    when defined, requests with req_addr+R-1 >= DEPTH
//                           are rejected (no RAM write, zero rdata, resp_err=1).
//                           When undefined, resp_err is 0 and indices wrap
//                           modulo DEPTH.
module vector_mem_responder #(
  parameter int I     = 32,
  parameter int N     = 8,
  parameter int R     = 6,
  parameter int DEPTH = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [I-1:0]        req_addr,
  input  logic [R-1:0][N-1:0] req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp_we,
  output logic [R-1:0][N-1:0] resp_rdata,
  output logic                resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int KW = (R > 1) ? $clog2(R) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(R - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic                 we_q, we_d;
  logic                 err_q, err_d;
  logic [R-1:0][N-1:0]  wdata_q, wdata_d;
  logic [R-1:0][N-1:0]  rdata_q, rdata_d;
  logic                 ready_q, ready_d;
  logic                 valid_q, valid_d;

  logic [N-1:0]         mem [DEPTH];

  logic                 accept_s;
  logic                 last_s;
  logic                 mem_we_s;
  logic                 req_err_s;
  logic [AW-1:0]        idx_s;

`ifdef VMEM_BOUNDS_CHECK_EN
  logic [I:0]           req_end_s;

  // Bounds check on the full address, one bit wider so the end address cannot overflow.
  always_comb begin
    req_end_s = {1'b0, req_addr} + (I+1)'(R - 1);
    req_err_s = (req_end_s >= (I+1)'(DEPTH));
  end
`else
  logic                 unused_addr_s;

  // Without the check the upper address bits play no part; indices wrap.
  assign unused_addr_s = ^req_addr[I-1:AW];
  assign req_err_s     = 1'b0;
`endif

  assign accept_s = req_valid && ready_q;
  assign last_s   = (k_q == K_LAST);
  // Modular add: a vector straddling DEPTH-1 continues at index 0.
  assign idx_s    = addr_q + AW'(k_q);
  // Rejected requests still walk through ACCESS but never touch the RAM.
  assign mem_we_s = (state_q == ACCESS) && we_q && !err_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) state_d = ACCESS;
        else          state_d = IDLE;
      end
      ACCESS: begin
        if (last_s) state_d = RESP;
        else        state_d = ACCESS;
      end
      RESP: begin
        // No same-cycle re-accept: always pass through IDLE after a handshake.
        if (valid_q && resp_ready) state_d = IDLE;
        else                       state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: handshake flags are registered from the next state.
  always_comb begin
    ready_d = (state_d == IDLE);
    valid_d = (state_d == RESP);
  end

  // Request capture, lane counter and load-data assembly.
  always_comb begin
    k_d     = k_q;
    addr_d  = addr_q;
    we_d    = we_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (accept_s) begin
      k_d     = '0;
      addr_d  = req_addr[AW-1:0];
      we_d    = req_we;
      err_d   = req_err_s;
      wdata_d = req_wdata;
      rdata_d = '0;
    end else if (state_q == ACCESS) begin
      if (last_s) k_d = '0;
      else        k_d = k_q + KW'(1);
      if (!we_q && !err_q) rdata_d[k_q] = mem[idx_s];
      else                 rdata_d = rdata_q;
    end else begin
      k_d = k_q;
    end
  end

  // Control and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_q     <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      k_q     <= k_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  // RAM write port; contents are deliberately untouched by reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) mem[idx_s] <= wdata_q[k_q];
  end

  assign req_ready  = ready_q;
  assign resp_valid = valid_q;
  assign resp_we    = we_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_vector_mem_responder.sv
module tb_vector_mem_responder;
  localparam int I = 32, N = 8, R = 6, DEPTH = 1024;

  logic                clk = 1'b0;
  logic                reset, req_valid, req_ready, req_we;
  logic                resp_valid, resp_ready, resp_we, resp_err;
  logic [I-1:0]        req_addr;
  logic [R-1:0][N-1:0] req_wdata, resp_rdata;

  typedef struct {
    logic                we;
    logic [R-1:0][N-1:0] rdata;
    logic                err;
    logic [R-1:0]        mask;
  } exp_t;

  exp_t         exp_q[$];
  logic [N-1:0] ref_mem [DEPTH];
  bit           ref_known [DEPTH];
  int           errors = 0;
  int           checks = 0;

  vector_mem_responder #(.I(I), .N(N), .R(R), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_we(resp_we),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  // Reference model: updates the shadow memory and queues the expected response.
  task automatic model_req(input logic we, input logic [I-1:0] addr, input logic [R-1:0][N-1:0] wd);
    exp_t e;
    int   idx;
    logic [I:0] last;
    e.we = we; e.rdata = '0; e.err = 1'b0; e.mask = '1;
    last = {1'b0, addr} + (I+1)'(R - 1);
`ifdef VMEM_BOUNDS_CHECK_EN
    if (last >= (I+1)'(DEPTH)) e.err = 1'b1;
`endif
    for (int k = 0; k < R; k++) begin
      idx = (int'(addr % DEPTH) + k) % DEPTH;
      if (!e.err) begin
        if (we) begin
          ref_mem[idx] = wd[k]; ref_known[idx] = 1'b1;
        end else begin
          e.rdata[k] = ref_mem[idx]; e.mask[k] = ref_known[idx];
        end
      end
    end
    exp_q.push_back(e);
  endtask

  // Drive a request until accepted (entered and left just after a falling edge).
  task automatic send_req(input logic we, input logic [I-1:0] addr, input logic [R-1:0][N-1:0] wd,
                          input bit use_model, output bit ok);
    int n = 0;
    ok = 1'b0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    while (!ok && n < 50) begin
      if (req_ready === 1'b1) begin
        @(posedge clk);
        if (use_model) model_req(we, addr, wd);
        ok = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
  endtask

  // Wait for a response, capture it, and complete the handshake.
  task automatic get_resp(output bit got, output int lat, output logic we,
                          output logic [R-1:0][N-1:0] rd, output logic err);
    got = 1'b0; lat = 0; we = 1'b0; rd = '0; err = 1'b0;
    resp_ready = 1'b1;
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      if (resp_valid === 1'b1) begin
        got = 1'b1; we = resp_we; rd = resp_rdata; err = resp_err;
        @(posedge clk);
        @(negedge clk);
      end
    end
  endtask

  task automatic run_req(input logic we, input logic [I-1:0] addr, input logic [R-1:0][N-1:0] wd,
                         output bit got, output int lat, output logic rwe,
                         output logic [R-1:0][N-1:0] rd, output logic rerr);
    bit ok;
    send_req(we, addr, wd, 1'b1, ok);
    if (ok) get_resp(got, lat, rwe, rd, rerr);
    else begin got = 1'b0; lat = 0; rwe = 1'b0; rd = '0; rerr = 1'b0; end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks += 5;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b required 0", req_ready); end
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b required 0", resp_valid); end
    if (resp_we !== 1'b0) begin errors++; $display("FAIL reset_resp_we: got %b required 0", resp_we); end
    if (resp_rdata !== '0) begin errors++; $display("FAIL reset_resp_rdata: got %h required 0", resp_rdata); end
    if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b required 0", resp_err); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks += 2;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_req_ready: got %b required 1", req_ready); end
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL idle_resp_valid: got %b required 0", resp_valid); end
  endtask

  task automatic test_store_load();
    logic [R-1:0][N-1:0] wd, rd;
    logic [I-1:0] addr, raddr;
    logic we, rwe, rerr;
    bit got, bad;
    int lat;
    exp_t e;
    raddr = '0;
    for (int i = 0; i < 10; i++) begin
      wd = '0;
      if (i == 0) begin
        we = 1'b1; addr = 32'h10;
        for (int k = 0; k < R; k++) wd[k] = N'(8'h11 * (k + 1));
      end else if (i == 1) begin
        we = 1'b0; addr = 32'h10;
      end else if (i % 2 == 0) begin
        we = 1'b1; raddr = I'($urandom_range(256, 760)); addr = raddr;
        for (int k = 0; k < R; k++) wd[k] = N'($urandom);
      end else begin
        we = 1'b0; addr = raddr;
      end
      run_req(we, addr, wd, got, lat, rwe, rd, rerr);
      checks++;
      if (!got || exp_q.size() == 0) begin
        errors++; $display("FAIL store_load_resp[%0d]: got no response, required one", i);
      end else begin
        e = exp_q.pop_front();
        bad = 1'b0;
        for (int k = 0; k < R; k++) if (e.mask[k] && rd[k] !== e.rdata[k]) bad = 1'b1;
        checks += 3;
        if (lat != R) begin errors++; $display("FAIL store_load_lat[%0d]: got %0d required %0d", i, lat, R); end
        if (rwe !== e.we || rerr !== e.err) begin
          errors++; $display("FAIL store_load_we_err[%0d]: got we=%b err=%b required we=%b err=%b", i, rwe, rerr, e.we, e.err);
        end
        if (bad) begin errors++; $display("FAIL store_load_rdata[%0d]: got %h required %h", i, rd, e.rdata); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [R-1:0][N-1:0] snap_rd, wd, rd;
    logic snap_we, snap_err, rwe, rerr;
    bit ok, got, bad;
    int n, lat;
    exp_t e;
    resp_ready = 1'b0;
    send_req(1'b0, 32'h10, '0, 1'b1, ok);
    n = 0;
    while (resp_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (!ok || n != R) begin errors++; $display("FAIL bp_latency: got %0d cycles required %0d", n, R); end
    snap_rd = resp_rdata; snap_we = resp_we; snap_err = resp_err;
    for (int k = 0; k < R; k++) wd[k] = N'(8'h70 + k);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h80; req_wdata = wd;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_rdata !== snap_rd || resp_err !== snap_err ||
          resp_we !== snap_we || req_ready !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL bp_stable: got change while stalled, required stable outputs and req_ready=0"); end
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL bp_first_resp: got no expectation, required one");
    end else begin
      e = exp_q.pop_front();
      bad = 1'b0;
      for (int k = 0; k < R; k++) if (e.mask[k] && snap_rd[k] !== e.rdata[k]) bad = 1'b1;
      if (bad || snap_we !== e.we || snap_err !== e.err) begin
        errors++; $display("FAIL bp_first_resp: got %h we=%b err=%b required %h we=%b err=%b", snap_rd, snap_we, snap_err, e.rdata, e.we, e.err);
      end
    end
    resp_ready = 1'b1;
    @(negedge clk);
    checks += 2;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_handshake: got resp_valid=%b required 0", resp_valid); end
    if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_idle_ready: got %b required 1", req_ready); end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_accept_1cycle: got req_ready=%b required 0", req_ready); end
    model_req(1'b1, 32'h80, wd);
    req_valid = 1'b0;
    get_resp(got, lat, rwe, rd, rerr);
    checks++;
    if (!got || exp_q.size() == 0) begin
      errors++; $display("FAIL bp_second_resp: got no response, required one");
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (lat != R || rwe !== e.we || rerr !== e.err || rd !== e.rdata) begin
        errors++; $display("FAIL bp_second_resp: got lat=%0d we=%b err=%b %h required lat=%0d we=%b err=%b %h", lat, rwe, rerr, rd, R, e.we, e.err, e.rdata);
      end
    end
  endtask

  task automatic test_wrap();
    logic [I-1:0] addr_t [7] = '{32'h3FA, 32'h000, 32'h3FE, 32'h000, 32'h3FA, 32'h3FE, 32'h0001_0010};
    logic         we_t   [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [N-1:0] base_t [7] = '{8'hC0, 8'hD0, 8'hA0, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [R-1:0][N-1:0] wd, rd;
    logic rwe, rerr;
    bit got, bad;
    int lat;
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < R; k++) wd[k] = we_t[i] ? N'(base_t[i] + k) : '0;
      run_req(we_t[i], addr_t[i], wd, got, lat, rwe, rd, rerr);
      checks++;
      if (!got || exp_q.size() == 0) begin
        errors++; $display("FAIL wrap_resp[%0d]: got no response, required one", i);
      end else begin
        e = exp_q.pop_front();
        bad = 1'b0;
        for (int k = 0; k < R; k++) if (e.mask[k] && rd[k] !== e.rdata[k]) bad = 1'b1;
        checks += 2;
        if (rwe !== e.we || rerr !== e.err) begin
          errors++; $display("FAIL wrap_we_err[%0d]: got we=%b err=%b required we=%b err=%b", i, rwe, rerr, e.we, e.err);
        end
        if (bad) begin errors++; $display("FAIL wrap_rdata[%0d]: got %h required %h", i, rd, e.rdata); end
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [R-1:0][N-1:0] wd, rd;
    logic rwe, rerr;
    bit ok, got, bad;
    int lat;
    exp_t e;
    for (int k = 0; k < R; k++) wd[k] = N'(8'h30 + k);
    run_req(1'b1, 32'h40, wd, got, lat, rwe, rd, rerr);
    checks++;
    if (!got || exp_q.size() == 0) begin errors++; $display("FAIL abort_prestore: got no response, required one"); end
    else e = exp_q.pop_front();
    for (int k = 0; k < R; k++) wd[k] = N'(8'hF0 + k);
    send_req(1'b1, 32'h40, wd, 1'b0, ok);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    for (int k = 0; k < 3; k++) begin ref_mem[32'h40 + k] = wd[k]; ref_known[32'h40 + k] = 1'b1; end
    @(negedge clk);
    checks++;
    if (!ok || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++; $display("FAIL abort_in_reset: got accepted=%b resp_valid=%b req_ready=%b required 1 0 0", ok, resp_valid, req_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    bad = 1'b0;
    repeat (8) begin @(negedge clk); if (resp_valid !== 1'b0) bad = 1'b1; end
    checks++;
    if (bad) begin errors++; $display("FAIL abort_no_resp: got resp_valid=1 after reset, required 0"); end
    run_req(1'b0, 32'h40, '0, got, lat, rwe, rd, rerr);
    checks++;
    if (!got || exp_q.size() == 0) begin
      errors++; $display("FAIL abort_load: got no response, required one");
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (rd !== e.rdata || rerr !== e.err) begin
        errors++; $display("FAIL abort_load: got %h err=%b required %h err=%b", rd, rerr, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_ignore();
    logic [R-1:0][N-1:0] rd;
    logic rwe, rerr;
    bit ok, got, bad;
    int lat;
    exp_t e;
    send_req(1'b0, 32'h10, '0, 1'b1, ok);
    bad = 1'b0;
    for (int i = 0; i < R - 1; i++) begin
      req_valid = (i % 2 == 0); req_we = 1'b1;
      req_addr = I'(32'h10 + i); req_wdata = {R{8'hEE}};
      if (req_ready !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    req_valid = 1'b0;
    checks++;
    if (!ok || bad) begin errors++; $display("FAIL ignore_ready: got accepted=%b ready_seen=%b required 1 0", ok, bad); end
    for (int j = 0; j < 2; j++) begin
      if (j == 0) get_resp(got, lat, rwe, rd, rerr);
      else run_req(1'b0, 32'h10, '0, got, lat, rwe, rd, rerr);
      checks++;
      if (!got || exp_q.size() == 0) begin
        errors++; $display("FAIL ignore_resp[%0d]: got no response, required one", j);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (rd !== e.rdata || rwe !== e.we || rerr !== e.err) begin
          errors++; $display("FAIL ignore_resp[%0d]: got %h we=%b err=%b required %h we=%b err=%b", j, rd, rwe, rerr, e.rdata, e.we, e.err);
        end
      end
      bad = 1'b0;
      repeat (4) begin @(negedge clk); if (resp_valid !== 1'b0) bad = 1'b1; end
      checks++;
      if (bad) begin errors++; $display("FAIL ignore_extra_resp[%0d]: got extra resp_valid, required none", j); end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_backpressure();
    test_wrap();
    test_reset_abort();
    test_ignore();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1);
  end

endmodule
